int_arbiter: RTL and testbench

//  Memory-mapped interrupt controller between the external interrupt pin, the two

---
 rtl/int_arbiter.sv | 119 +++++++++++
 tb/tb_int_arbiter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/int_arbiter.sv
// Interrupt controller: pending/mask/mode registers, fixed-priority pick,
// one interrupt at a time handed to the pipeline over req/ack, released by EOI.
module int_arbiter #(
    parameter int          N_SRC     = 6,
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [29:0]      Addr,
    input  logic             WE,
    input  logic [31:0]      Din,
    output logic [31:0]      Dout,
    input  logic [N_SRC-1:0] src,
    output logic             int_req,
    output logic [2:0]       int_id,
    input  logic             int_ack
);

    typedef enum logic [1:0] {IDLE, REQ, SVC} state_t;

    localparam logic [27:0] BASE_W = BASE_ADDR[31:4];

    state_t state, state_nxt;

    logic [N_SRC-1:0] mask, pend, mode, src_q;
    logic [N_SRC-1:0] act, rise, w1c, cur_oh, ack_clr, pend_nxt;
    logic [2:0]       sel, id_nxt;
    logic [1:0]       off;
    logic             hit, wr, eoi, ack_ev, act_cur;
    logic             unused_din;

    assign hit        = Addr[29:2] == BASE_W;
    assign off        = Addr[1:0];
    assign wr         = WE & hit;
    assign eoi        = wr && (off == 2'd3);
    assign unused_din = ^Din[31:N_SRC];

    assign act     = pend & mask;
    assign rise    = src & ~src_q;
    assign ack_ev  = (state == REQ) && int_ack;
    assign act_cur = |(act & cur_oh);
    assign int_req = (state == REQ);

    always_comb begin
        sel    = '0;
        cur_oh = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (act[i])
                sel = 3'(i);
            cur_oh[i] = (int_id == 3'(i));
        end
    end

    // A new edge beats both a W1C and the ack-clear on the same bit.
    always_comb begin
        w1c      = (wr && off == 2'd1) ? Din[N_SRC-1:0] : '0;
        ack_clr  = ack_ev ? cur_oh : '0;
        pend_nxt = (mode & (rise | (pend & ~w1c & ~ack_clr)))
                 | (~mode & src);
    end

    always_comb begin
        state_nxt = state;
        id_nxt    = int_id;
        unique case (state)
            IDLE: begin
                if (|act) begin
                    state_nxt = REQ;
                    id_nxt    = sel;
                end
            end
            REQ: begin
                if (int_ack)
                    state_nxt = SVC;
                else if (!act_cur)
                    state_nxt = IDLE;
            end
            SVC: begin
                if (eoi)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            int_id <= '0;
            mask   <= '0;
            pend   <= '0;
            mode   <= '0;
            src_q  <= '0;
        end else begin
            state  <= state_nxt;
            int_id <= id_nxt;
            pend   <= pend_nxt;
            src_q  <= src;
            if (wr && off == 2'd0)
                mask <= Din[N_SRC-1:0];
            if (wr && off == 2'd2)
                mode <= Din[N_SRC-1:0];
        end
    end

    always_comb begin
        Dout = '0;
        if (hit) begin
            unique case (off)
                2'd0: Dout = 32'(mask);
                2'd1: Dout = 32'(pend);
                2'd2: Dout = 32'(mode);
                2'd3: Dout = {state == SVC, 28'b0, int_id};
                default: Dout = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_int_arbiter.sv
// Bench for int_arbiter: directed scenarios plus randomized traffic,
// all checked cycle by cycle against a behavioural model of the controller.
module tb_int_arbiter;

    localparam int          N  = 6;
    localparam logic [29:0] BW = 30'h0000_1FC8;

    logic         clk = 1'b0;
    logic         reset, WE, int_req, int_ack;
    logic [29:0]  Addr;
    logic [31:0]  Din, Dout;
    logic [N-1:0] src;
    logic [2:0]   int_id;

    int checks = 0;
    int errors = 0;

    // Model state: st 0 = idle, 1 = requesting, 2 = in service
    bit [N-1:0] m_mask, m_pend, m_mode, m_srcq;
    int         m_st;
    int         m_id;

    int_arbiter #(.N_SRC(N), .BASE_ADDR(32'h0000_7F20)) dut (
        .clk(clk), .reset(reset), .Addr(Addr), .WE(WE), .Din(Din),
        .Dout(Dout), .src(src), .int_req(int_req), .int_id(int_id),
        .int_ack(int_ack)
    );

    always #5 clk = ~clk;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_read(logic [29:0] a);
        int off;
        if (a < BW || a > BW + 30'd3) return 32'h0;
        off = int'(a - BW);
        case (off)
            0: return 32'(m_mask);
            1: return 32'(m_pend);
            2: return 32'(m_mode);
            default: return {m_st == 2, 28'b0, 3'(m_id)};
        endcase
    endfunction

    task automatic m_step();
        bit [N-1:0] act, np, clr;
        bit         wr;
        int         off, sel;
        if (reset) begin
            m_mask = '0; m_pend = '0; m_mode = '0; m_srcq = '0;
            m_st = 0; m_id = 0;
            return;
        end
        wr  = WE && Addr >= BW && Addr <= BW + 30'd3;
        off = int'(Addr - BW);
        act = m_pend & m_mask;
        clr = '0;
        sel = -1;
        for (int i = 0; i < N; i++)
            if (act[i] && sel < 0) sel = i;
        case (m_st)
            0: if (sel >= 0) begin m_id = sel; m_st = 1; end
            1: begin
                if (int_ack) begin m_st = 2; clr[m_id] = 1'b1; end
                else if (!act[m_id]) m_st = 0;
            end
            default: if (wr && off == 3) m_st = 0;
        endcase
        for (int i = 0; i < N; i++) begin
            if (m_mode[i])
                np[i] = (src[i] && !m_srcq[i]) ||
                        (m_pend[i] && !(wr && off == 1 && Din[i]) && !clr[i]);
            else
                np[i] = src[i];
        end
        if (wr && off == 0) m_mask = Din[N-1:0];
        if (wr && off == 2) m_mode = Din[N-1:0];
        m_pend = np;
        m_srcq = src;
    endtask

    task automatic cyc(logic r, logic [N-1:0] s, logic w,
                       logic [29:0] a, logic [31:0] d, logic k);
        @(negedge clk);
        reset = r; src = s; WE = w; Addr = a; Din = d; int_ack = k;
        #1;
        check("dout", Dout, m_read(Addr));
        check("int_req", 32'(int_req), 32'(m_st == 1));
        check("int_id", 32'(int_id), 32'(m_id));
        @(posedge clk);
        #1;
        m_step();
    endtask

    task automatic rd(int off, logic [31:0] exp, string tag);
        Addr = BW + 30'(off);
        WE   = 1'b0;
        #1;
        check(tag, Dout, exp);
    endtask

    initial begin
        logic [N-1:0] s;
        logic [29:0]  a;
        int           pick;
        reset = 1'b1; src = '0; WE = 1'b0; Addr = BW; Din = '0; int_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        m_step();
        check("rst_req", 32'(int_req), 32'h0);
        check("rst_id", 32'(int_id), 32'h0);
        for (int i = 0; i < 4; i++) rd(i, 32'h0, "rst_reg");

        // Edge source 0: request two cycles after the pulse, ack clears it
        cyc(0, 6'h00, 1, BW, 32'h3F, 0);
        cyc(0, 6'h00, 1, BW + 30'd2, 32'h01, 0);
        cyc(0, 6'h01, 0, BW, 0, 0);
        check("s1_req_early", 32'(int_req), 32'h0);
        cyc(0, 6'h00, 0, BW, 0, 0);
        check("s1_req", 32'(int_req), 32'h1);
        check("s1_id", 32'(int_id), 32'h0);
        cyc(0, 6'h00, 0, BW, 0, 1);
        rd(1, 32'h0, "s1_pend");
        rd(3, 32'h8000_0000, "s1_cur");
        cyc(0, 6'h00, 1, BW + 30'd3, 0, 0);
        check("s1_eoi_req", 32'(int_req), 32'h0);

        // Set beats W1C; W1C on a level bit does nothing
        cyc(0, 6'h01, 1, BW + 30'd1, 32'h1, 0);
        rd(1, 32'h1, "s5_set_wins");
        cyc(0, 6'h03, 1, BW + 30'd1, 32'h2, 0);
        rd(1, 32'h3, "s5_lvl_w1c");

        // Reset out of service
        cyc(0, 6'h03, 0, BW, 0, 1);
        rd(3, 32'h8000_0000, "s6_svc");
        cyc(1, 6'h00, 0, BW, 0, 0);
        check("s6_req", 32'(int_req), 32'h0);
        for (int i = 0; i < 4; i++) rd(i, 32'h0, "s6_reg");

        cyc(1, 6'h00, 0, BW, 0, 0);
        s = '0;
        for (int n = 0; n < 3000; n++) begin
            s    = s ^ N'($urandom & $urandom);
            pick = $urandom_range(0, 9);
            if (pick < 8)       a = BW + 30'($urandom_range(0, 3));
            else if (pick == 8) a = BW + 30'd4;
            else                a = BW - 30'd1;
            cyc($urandom_range(0, 199) == 0, s, $urandom_range(0, 99) < 15,
                a, $urandom, $urandom_range(0, 3) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
